// File: rtl/mem_dual_bank_if.sv
// Bus bundle between the memory-op pipeline stage and the dual-bank data memory.
// Two word ports, each with address, write strobe, write data and read data,
// plus the busy flag that stalls the stage while the memory clears itself.
interface mem_dual_bank_if #(
    parameter int SIZE_ADDR = 16,
    parameter int SIZE_DATA = 16
);
    logic [SIZE_ADDR-1:0] iw_mem_addr  [0:1];
    logic                 iw_mem_we    [0:1];
    logic [SIZE_DATA-1:0] iw_mem_wdata [0:1];
    logic [SIZE_DATA-1:0] ow_mem_rdata [0:1];
    logic                 ow_busy;

    // Pipeline stage side: drives addresses and writes, consumes read data.
    modport master (
        output iw_mem_addr,
        output iw_mem_we,
        output iw_mem_wdata,
        input  ow_mem_rdata,
        input  ow_busy
    );

    // Memory side.
    modport slave (
        input  iw_mem_addr,
        input  iw_mem_we,
        input  iw_mem_wdata,
        output ow_mem_rdata,
        output ow_busy
    );
endinterface

// File: rtl/mem_dual_bank.sv
// Dual-bank data memory for the memory-op stage. Port p owns bank p outright,
// so simultaneous writes never collide. Reads are combinational and
// write-first. After every reset a sweep FSM zeroes both banks, one word per
// bank per cycle, and holds ow_busy high until the last word is cleared.
module mem_dual_bank #(
    parameter int DEPTH_LOG2 = 8,
    parameter int SIZE_ADDR  = 16,
    parameter int SIZE_DATA  = 16
) (
    input  logic            iw_clk,
    input  logic            iw_rst,
    mem_dual_bank_if.slave  mem
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {
        S_CLEAR,
        S_READY
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [DEPTH_LOG2:0] idx;
    logic [DEPTH_LOG2:0] idx_next;
    logic                clearing;

    assign clearing    = (state == S_CLEAR);
    assign mem.ow_busy = clearing;

    // State and sweep index register; reset restarts the sweep from word 0.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of block ordering.
    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            state <= S_CLEAR;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // Sweep sequencing: advance one word per cycle, leave after the last one.
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            S_CLEAR: begin
                idx_next = idx + 1'b1;
                if (idx[DEPTH_LOG2-1:0] == {DEPTH_LOG2{1'b1}}) begin
                    state_next = S_READY;
                end
            end
            S_READY: begin
                idx_next = idx;
            end
            default: begin
                state_next = S_CLEAR;
                idx_next   = '0;
            end
        endcase
    end

    for (genvar p = 0; p < 2; p++) begin : g_bank
        logic [SIZE_DATA-1:0]  words [0:DEPTH-1];
        logic [DEPTH_LOG2-1:0] addr;
        logic                  unused_addr_hi;

        // Upper address bits are deliberately ignored: addresses wrap.
        assign addr           = mem.iw_mem_addr[p][DEPTH_LOG2-1:0];
        assign unused_addr_hi = ^mem.iw_mem_addr[p][SIZE_ADDR-1:DEPTH_LOG2];

        // Bank storage: the sweep owns the write port while clearing,
        // otherwise the pipeline port writes when strobed.
        // NOTE: the array has no reset term; the sweep FSM zeroes it instead,
        // which keeps it mappable onto RAM primitives.
        always_ff @(posedge iw_clk) begin
            if (clearing) begin
                words[idx[DEPTH_LOG2-1:0]] <= '0;
            end else if (mem.iw_mem_we[p]) begin
                words[addr] <= mem.iw_mem_wdata[p];
            end
        end

        // Read path: zero while clearing, write-first bypass, else the array.
        always_comb begin
            mem.ow_mem_rdata[p] = '0;
            if (!clearing) begin
                if (mem.iw_mem_we[p]) begin
                    mem.ow_mem_rdata[p] = mem.iw_mem_wdata[p];
                end else begin
                    mem.ow_mem_rdata[p] = words[addr];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_dual_bank.sv
// Scoreboard bench for mem_dual_bank (DEPTH_LOG2 = 4). The driver applies one
// cycle of stimulus, predicts the outputs for that cycle from a behavioural
// model, and queues the prediction; the monitor pops and compares mid-cycle.
module tb_mem_dual_bank;
    localparam int DL    = 4;
    localparam int DEPTH = 1 << DL;
    localparam int AW    = 8;
    localparam int DW    = 16;

    typedef struct {
        logic          busy;
        logic [DW-1:0] rdata [0:1];
    } exp_t;

    logic iw_clk;
    logic iw_rst;

    mem_dual_bank_if #(.SIZE_ADDR(AW), .SIZE_DATA(DW)) bus ();

    mem_dual_bank #(
        .DEPTH_LOG2 (DL),
        .SIZE_ADDR  (AW),
        .SIZE_DATA  (DW)
    ) dut (
        .iw_clk (iw_clk),
        .iw_rst (iw_rst),
        .mem    (bus)
    );

    exp_t exp_q [$];
    int   n_tests = 0;
    int   n_fails = 0;

    // Behavioural model: contents per bank, and how many busy cycles remain.
    logic [DW-1:0] ref_mem [0:1][0:DEPTH-1];
    int            clear_rem = 0;

    initial begin
        iw_clk = 1'b0;
        forever #5 iw_clk = ~iw_clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: one prediction per cycle, compared away from the clock edge.
    always @(negedge iw_clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("busy",   {{(DW-1){1'b0}}, bus.ow_busy}, {{(DW-1){1'b0}}, e.busy});
            check("rdata0", bus.ow_mem_rdata[0], e.rdata[0]);
            check("rdata1", bus.ow_mem_rdata[1], e.rdata[1]);
        end
    end

    // Drive one cycle, queue its prediction, then advance the model at the edge.
    task automatic step(input logic rst,
                        input logic we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        exp_t          e;
        logic          we   [0:1];
        logic [AW-1:0] a    [0:1];
        logic [DW-1:0] d    [0:1];
        we[0] = we0; a[0] = a0; d[0] = d0;
        we[1] = we1; a[1] = a1; d[1] = d1;
        iw_rst = rst;
        for (int p = 0; p < 2; p++) begin
            bus.iw_mem_we[p]    = we[p];
            bus.iw_mem_addr[p]  = a[p];
            bus.iw_mem_wdata[p] = d[p];
        end
        e.busy = (clear_rem > 0);
        for (int p = 0; p < 2; p++) begin
            if (e.busy)     e.rdata[p] = '0;
            else if (we[p]) e.rdata[p] = d[p];
            else            e.rdata[p] = ref_mem[p][int'(a[p]) % DEPTH];
        end
        exp_q.push_back(e);
        @(posedge iw_clk);
        if (rst) begin
            clear_rem = DEPTH;
        end else if (clear_rem > 0) begin
            clear_rem--;
            if (clear_rem == 0) begin
                for (int p = 0; p < 2; p++)
                    for (int i = 0; i < DEPTH; i++) ref_mem[p][i] = '0;
            end
        end else begin
            for (int p = 0; p < 2; p++)
                if (we[p]) ref_mem[p][int'(a[p]) % DEPTH] = d[p];
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        step(1'b0, 1'b0, a0, '0, 1'b0, a1, '0);
    endtask

    task automatic pulse_reset();
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[p][i] = '0;
            bus.iw_mem_we[p]    = 1'b0;
            bus.iw_mem_addr[p]  = '0;
            bus.iw_mem_wdata[p] = '0;
        end
        // First edge only establishes a known state; nothing to predict before it.
        iw_rst = 1'b1;
        @(posedge iw_clk);
        clear_rem = DEPTH;
        #1;

        // Reset and clear: 16 busy cycles with zero read data, then all zero.
        idle(DEPTH);
        for (int i = 0; i < DEPTH; i++) rd(AW'(i), AW'(DEPTH - 1 - i));

        // Write and read back with bypass; the other bank is untouched.
        step(1'b0, 1'b1, 8'h03, 16'hA5A5, 1'b0, 8'h03, '0);
        rd(8'h03, 8'h03);

        // Dual simultaneous writes to the same address.
        step(1'b0, 1'b1, 8'h07, 16'h1111, 1'b1, 8'h07, 16'h2222);
        rd(8'h07, 8'h07);

        // Address wrap on port 1.
        step(1'b0, 1'b0, '0, '0, 1'b1, 8'h13, 16'hBEEF);
        rd(8'h03, 8'h03);
        rd(8'h23, 8'hF3);

        // Writes during clear are dropped, including the last sweep cycle.
        pulse_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00, 16'hFFFF, 1'b1, 8'h00, 16'hFFFF);
        rd(8'h00, 8'h00);
        rd(8'h03, 8'h07);

        // Reset mid-sweep restarts the full 16-cycle sweep.
        step(1'b0, 1'b1, 8'h09, 16'h5555, 1'b1, 8'h09, 16'h5555);
        rd(8'h09, 8'h09);
        pulse_reset();
        idle(5);
        pulse_reset();
        idle(DEPTH);
        rd(8'h09, 8'h09);

        // Held reset: busy stays up, sweep starts on release.
        step(1'b0, 1'b1, 8'h02, 16'h0F0F, 1'b0, '0, '0);
        for (int i = 0; i < 3; i++) pulse_reset();
        idle(DEPTH);
        rd(8'h02, 8'h02);

        // Randomized traffic with occasional resets and narrow address range.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 149) == 0),
                 1'($urandom_range(0, 1)), AW'($urandom_range(0, 40)), DW'($urandom),
                 1'($urandom_range(0, 1)), AW'($urandom_range(0, 40)), DW'($urandom));
        end

        // Final read-out of every word once the memory is ready.
        idle(DEPTH + 1);
        for (int i = 0; i < DEPTH; i++) rd(AW'(i), AW'(i + DEPTH));

        @(negedge iw_clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end
endmodule
